// File: rtl/aes_key_schedule_iter.sv
// Iterative AES key schedule for AES-128/192/256 (NK = 4/6/8).
// Produces one expanded-key word per clock from a sliding window of the last NK
// words and streams the NR+1 round keys over a valid/ready handshake.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     begin expansion (sampled only while idle)
//   key_in    cipher key, w0 in the top 32 bits; captured on the start edge
//   busy      high from the start edge until the final handshake
//   rk_out    round key, first word in [127:96]
//   rk_valid  rk_out / rk_idx valid
//   rk_ready  consumer accepts the round key
//   rk_idx    round-key index, 0..NR
//   done      one-cycle pulse after round key NR is accepted
module aes_key_schedule_iter #(
    parameter int unsigned NK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NK*32-1:0] key_in,
    output logic             busy,
    output logic [127:0]     rk_out,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [3:0]       rk_idx,
    output logic             done
);

    localparam int unsigned NR      = NK + 6;
    localparam int unsigned KW      = NK * 32;
    localparam logic [5:0]  NK_W    = 6'(NK);
    localparam logic [3:0]  NR_W    = 4'(NR);
    localparam logic [2:0]  NK_LAST = 3'(NK - 1);

    generate
        if (NK != 4 && NK != 6 && NK != 8) begin : gen_bad_nk
            $error("aes_key_schedule_iter: NK must be 4, 6 or 8");
        end
    endgenerate

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {StIdle, StGen, StHold} state_e;

    state_e          state_q;
    logic [KW-1:0]   win_q;    // last NK words, oldest (w[i-NK]) at the top
    logic [127:0]    asm_q;    // last four generated words
    logic [5:0]      i_q;      // expanded-word counter
    logic [2:0]      kcnt_q;   // i mod NK, kept separately to avoid a divider
    logic [7:0]      rcon_q;

    logic [31:0] top_word;
    logic [31:0] prev_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] t_word;
    logic [31:0] new_word;
    logic [7:0]  rcon_next;
    logic        key_phase;

    always_comb begin
        top_word  = win_q[KW-1 -: 32];
        prev_word = win_q[31:0];
        key_phase = (i_q < NK_W);

        // RotWord only on the rcon step; the AES-256 mid-key step is SubWord alone.
        sub_in  = (kcnt_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        sub_out = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]],
                   SBOX[sub_in[15:8]],  SBOX[sub_in[7:0]]};

        if (kcnt_q == 3'd0) begin
            t_word = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && kcnt_q == 3'd4) begin
            t_word = sub_out;
        end else begin
            t_word = prev_word;
        end

        // While emitting the key itself the window just rotates, so after NK
        // words it is back in order with w0 on top, ready for w[i-NK].
        new_word  = key_phase ? top_word : (top_word ^ t_word);
        rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            win_q    <= '0;
            asm_q    <= '0;
            i_q      <= '0;
            kcnt_q   <= '0;
            rcon_q   <= '0;
            busy     <= 1'b0;
            rk_out   <= '0;
            rk_valid <= 1'b0;
            rk_idx   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        win_q   <= key_in;
                        i_q     <= '0;
                        kcnt_q  <= '0;
                        rcon_q  <= 8'h01;
                        busy    <= 1'b1;
                        state_q <= StGen;
                    end
                end
                StGen: begin
                    win_q  <= {win_q[KW-33:0], new_word};
                    asm_q  <= {asm_q[95:0], new_word};
                    i_q    <= i_q + 6'd1;
                    kcnt_q <= (kcnt_q == NK_LAST) ? 3'd0 : kcnt_q + 3'd1;
                    if (!key_phase && kcnt_q == 3'd0) begin
                        rcon_q <= rcon_next;
                    end
                    if (i_q[1:0] == 2'b11) begin
                        rk_out   <= {asm_q[95:0], new_word};
                        rk_valid <= 1'b1;
                        rk_idx   <= i_q[5:2];
                        state_q  <= StHold;
                    end
                end
                StHold: begin
                    if (rk_ready) begin
                        rk_valid <= 1'b0;
                        if (rk_idx == NR_W) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            state_q <= StGen;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_iter.sv
module tb_aes_key_schedule_iter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         start_s, ready_s;
    int           sel;
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;

    logic st4, st6, st8, rd4, rd6, rd8;
    logic busy4, busy6, busy8, v4, v6, v8, d4, d6, d8;
    logic [127:0] rk4, rk6, rk8;
    logic [3:0] idx4, idx6, idx8;

    assign st4 = start_s && (sel == 0);
    assign st6 = start_s && (sel == 1);
    assign st8 = start_s && (sel == 2);
    assign rd4 = ready_s && (sel == 0);
    assign rd6 = ready_s && (sel == 1);
    assign rd8 = ready_s && (sel == 2);

    aes_key_schedule_iter #(.NK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .key_in(key4), .busy(busy4), .rk_out(rk4),
        .rk_valid(v4), .rk_ready(rd4), .rk_idx(idx4), .done(d4));
    aes_key_schedule_iter #(.NK(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(st6), .key_in(key6), .busy(busy6), .rk_out(rk6),
        .rk_valid(v6), .rk_ready(rd6), .rk_idx(idx6), .done(d6));
    aes_key_schedule_iter #(.NK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .key_in(key8), .busy(busy8), .rk_out(rk8),
        .rk_valid(v8), .rk_ready(rd8), .rk_idx(idx8), .done(d8));

    logic         cur_valid, cur_busy, cur_done;
    logic [127:0] cur_rk;
    logic [3:0]   cur_idx;
    assign cur_valid = (sel == 0) ? v4 : (sel == 1) ? v6 : v8;
    assign cur_busy  = (sel == 0) ? busy4 : (sel == 1) ? busy6 : busy8;
    assign cur_done  = (sel == 0) ? d4 : (sel == 1) ? d6 : d8;
    assign cur_rk    = (sel == 0) ? rk4 : (sel == 1) ? rk6 : rk8;
    assign cur_idx   = (sel == 0) ? idx4 : (sel == 1) ? idx6 : idx8;

    int errors = 0;
    int checks = 0;

    logic [131:0] sb[$];       // {rk_idx, rk_out} expected per handshake
    logic [127:0] got[15];
    logic [7:0]   ref_sbox[256];

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box derived from GF(2^8) inversion plus the affine map, independent of any table.
    task automatic build_sbox();
        logic [7:0] inv, s, r;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = inv;
            r = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            ref_sbox[a] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {ref_sbox[w[31:24]], ref_sbox[w[23:16]], ref_sbox[w[15:8]], ref_sbox[w[7:0]]};
    endfunction

    task automatic push_model(input int nk, input logic [255:0] key);
        logic [31:0] w[60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            sb.push_back({4'(r), w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]});
        end
    endtask

    task automatic drive_key(input logic [255:0] key);
        key4 = key[255:128];
        key6 = key[255:64];
        key8 = key;
    endtask

    task automatic run(input int s, input logic [255:0] key, input int stall_idx,
                       input int stall_len, input bit poke, input int abort_idx,
                       output int done_cyc, output int first_valid, output int hs_count);
        int cyc, stall_cnt;
        bit hs, stalled;
        logic [131:0] held, e;
        sb.delete();
        push_model(4 + 2 * s, key);
        sel = s;
        done_cyc = -1;
        first_valid = -1;
        hs_count = 0;
        cyc = 0;
        stall_cnt = 0;
        @(negedge clk);
        drive_key(key);
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        while (done_cyc < 0 && cyc < 400) begin
            if (abort_idx >= 0 && cur_valid && cur_idx == 4'(abort_idx)) begin
                rst_n = 1'b0;
                #1;
                check("async_reset", {cur_busy, cur_valid, cur_idx, cur_done, cur_rk}, '0);
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                sb.delete();
                ready_s = 1'b0;
                return;
            end
            if (cur_valid && cur_idx == 4'(stall_idx) && stall_cnt < stall_len) begin
                ready_s = 1'b0;
                stall_cnt++;
            end else begin
                ready_s = 1'b1;
            end
            hs      = cur_valid && ready_s;
            stalled = cur_valid && !ready_s;
            held    = {cur_idx, cur_rk};
            if (poke && (cyc == 12 || cyc == 23)) begin
                start_s = 1'b1;
                drive_key(~key);
            end else begin
                start_s = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (cur_valid && first_valid < 0) first_valid = cyc;
            if (hs) begin
                hs_count++;
                got[held[131:128]] = held[127:0];
                if (sb.size() == 0) begin
                    check("sb_underflow", 136'(sb.size()), 136'd1);
                end else begin
                    e = sb.pop_front();
                    check("rk_handshake", held, e);
                end
            end
            if (stalled) check("stall_hold", {cur_valid, cur_idx, cur_rk}, {1'b1, held});
            if (cur_done) done_cyc = cyc;
        end
        start_s = 1'b0;
        ready_s = 1'b0;
        check("done_seen", 136'(done_cyc >= 0), 136'd1);
        check("sb_drained", 136'(sb.size()), 136'd0);
        check("busy_after_done", {cur_busy, cur_valid}, 136'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 136'(cur_done), 136'd0);
    endtask

    int dc, fv, hc;

    initial begin
        rst_n   = 1'b0;
        start_s = 1'b0;
        ready_s = 1'b0;
        sel     = 0;
        drive_key('0);
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        check("reset_nk4", {busy4, v4, idx4, d4, rk4}, '0);
        check("reset_nk6", {busy6, v6, idx6, d6, rk6}, '0);
        check("reset_nk8", {busy8, v8, idx8, d8, rk8}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // AES-128 streaming
        run(0, KEY128, -1, 0, 1'b0, -1, dc, fv, hc);
        check("s1_rk0", got[0], KEY128[255:128]);
        check("s1_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("s1_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("s1_first_valid", 136'(fv), 136'd4);
        check("s1_done_cycle", 136'(dc), 136'd55);
        check("s1_handshakes", 136'(hc), 136'd11);

        // AES-192
        run(1, KEY192, -1, 0, 1'b0, -1, dc, fv, hc);
        check("s2_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);
        check("s2_handshakes", 136'(hc), 136'd13);
        check("s2_done_cycle", 136'(dc), 136'd65);

        // AES-256
        run(2, KEY256, -1, 0, 1'b0, -1, dc, fv, hc);
        check("s3_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
        check("s3_done_cycle", 136'(dc), 136'd75);

        // Backpressure at rk3
        run(0, KEY128, 3, 7, 1'b0, -1, dc, fv, hc);
        check("s4_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("s4_done_cycle", 136'(dc), 136'd62);

        // start pulsed while busy with another key
        run(0, KEY128, -1, 0, 1'b1, -1, dc, fv, hc);
        check("s5_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("s5_done_cycle", 136'(dc), 136'd55);

        // Reset while rk5 is pending, then restart
        run(0, KEY128, -1, 0, 1'b0, 5, dc, fv, hc);
        #1;
        check("s6_post_reset", {cur_busy, cur_valid, cur_idx, cur_done, cur_rk}, '0);
        run(0, KEY128, -1, 0, 1'b0, -1, dc, fv, hc);
        check("s6_rk0", got[0], KEY128[255:128]);
        check("s6_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("s6_done_cycle", 136'(dc), 136'd55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
